// File: rtl/sys_ctrl_send_pkg.sv
// Shared definitions between the system controller's receive and send halves.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sys_ctrl_send_pkg;

    // Default width of one UART byte and of register-file data.
    localparam int DATA_WIDTH_DEF = 8;

    // Frame command bytes decoded by the receive-side controller.
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

endpackage

// File: rtl/sys_ctrl_send_buf.sv
// Single-entry result buffer with pending flag and drop detection.
// Latency: strobe captured on the edge it is sampled; pend visible the next cycle.
// Backpressure: none upstream; a strobe hitting a full entry is dropped and flagged on drop.
// Ports: CLK/RST clock and sync active-high reset; in_vld/in_dat incoming strobe and data;
//        clr releases the entry; buf_dat/pend stored data and occupancy; drop (comb) lost strobe.
module sys_ctrl_send_buf
    import sys_ctrl_send_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             clr,
    output logic [WIDTH-1:0] buf_dat,
    output logic             pend,
    output logic             drop
);

    logic accept;

    // The entry being released this cycle counts as free, so a strobe
    // arriving on the clearing edge refills it instead of being lost.
    assign accept = in_vld && (!pend || clr);
    assign drop   = in_vld && pend && !clr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_dat <= '0;
            pend    <= 1'b0;
        end else if (accept) begin
            buf_dat <= in_dat;
            pend    <= 1'b1;
        end else if (clr) begin
            pend    <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_ctrl_send.sv
// Sends register-read bytes and two-byte ALU results to the UART transmitter.
// Latency: strobe at edge N -> TX_D_VLD high after edge N+1 (sampled by TX at N+2).
// Backpressure: waits on Busy handshake per byte; one pending result per source, extra strobes dropped (ovf).
// Ports: CLK, RST (sync active-high); RdData/RdData_Valid and ALU_OUT/OUT_VALID result inputs;
//        sys_ctrl_send_en launch permission; Busy from UART TX; TX_P_DATA/TX_D_VLD byte out;
//        alu_out_done pulse after the ALU high byte; ovf pulse when a result is dropped.
module sys_ctrl_send
    import sys_ctrl_send_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    sys_ctrl_send_en,
    input  logic                    Busy,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    alu_out_done,
    output logic                    ovf
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state, state_d;

    logic [DATA_WIDTH-1:0]   rd_buf;
    logic [2*DATA_WIDTH-1:0] alu_buf;
    logic                    rd_pend, alu_pend;
    logic                    rd_drop, alu_drop;
    logic                    rd_clr, alu_clr;

    // Which byte is in flight: src_alu=0 register byte, else ALU byte hi_byte.
    logic                    src_alu, src_alu_d;
    logic                    hi_byte, hi_byte_d;
    logic [DATA_WIDTH-1:0]   tx_dat_d;
    logic                    tx_vld_d;
    logic                    done_d;
    logic                    launch;

    sys_ctrl_send_buf #(.WIDTH(DATA_WIDTH)) u_rd_buf (
        .CLK     (CLK),
        .RST     (RST),
        .in_vld  (RdData_Valid),
        .in_dat  (RdData),
        .clr     (rd_clr),
        .buf_dat (rd_buf),
        .pend    (rd_pend),
        .drop    (rd_drop)
    );

    sys_ctrl_send_buf #(.WIDTH(2*DATA_WIDTH)) u_alu_buf (
        .CLK     (CLK),
        .RST     (RST),
        .in_vld  (OUT_VALID),
        .in_dat  (ALU_OUT),
        .clr     (alu_clr),
        .buf_dat (alu_buf),
        .pend    (alu_pend),
        .drop    (alu_drop)
    );

    assign launch = (rd_pend || alu_pend) && sys_ctrl_send_en && !Busy;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (launch) state_d = LOAD;
            LOAD:      if (Busy)   state_d = WAIT_ACK;
            WAIT_ACK:  if (Busy)   state_d = WAIT_DONE;
            WAIT_DONE: begin
                // The ALU high byte follows its low byte directly, without
                // re-arbitration and regardless of sys_ctrl_send_en.
                if (!Busy) state_d = (src_alu && !hi_byte) ? LOAD : IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and buffer releases.
    always_comb begin
        tx_dat_d  = TX_P_DATA;
        tx_vld_d  = TX_D_VLD;
        done_d    = 1'b0;
        src_alu_d = src_alu;
        hi_byte_d = hi_byte;
        rd_clr    = 1'b0;
        alu_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    tx_vld_d  = 1'b1;
                    src_alu_d = !rd_pend;
                    hi_byte_d = 1'b0;
                    tx_dat_d  = rd_pend ? rd_buf : alu_buf[DATA_WIDTH-1:0];
                end
            end
            LOAD: begin
                if (Busy) tx_vld_d = 1'b0;
            end
            WAIT_DONE: begin
                if (!Busy) begin
                    if (!src_alu) begin
                        rd_clr = 1'b1;
                    end else if (!hi_byte) begin
                        tx_vld_d  = 1'b1;
                        hi_byte_d = 1'b1;
                        tx_dat_d  = alu_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        alu_clr = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and byte-select registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            TX_P_DATA    <= '0;
            TX_D_VLD     <= 1'b0;
            alu_out_done <= 1'b0;
            ovf          <= 1'b0;
            src_alu      <= 1'b0;
            hi_byte      <= 1'b0;
        end else begin
            TX_P_DATA    <= tx_dat_d;
            TX_D_VLD     <= tx_vld_d;
            alu_out_done <= done_d;
            ovf          <= rd_drop || alu_drop;
            src_alu      <= src_alu_d;
            hi_byte      <= hi_byte_d;
        end
    end

endmodule

// File: tb/tb_sys_ctrl_send.sv
// Directed bench for sys_ctrl_send: table of transfer scenarios plus corner sequences.
// Latency: n/a.
// Backpressure: a UART model raises Busy one cycle after TX_D_VLD and holds it for 10 cycles.
module tb_sys_ctrl_send;

    logic        CLK;
    logic        RST;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        sys_ctrl_send_en;
    logic        Busy;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        alu_out_done;
    logic        ovf;

    sys_ctrl_send #(.DATA_WIDTH(8)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .RdData           (RdData),
        .RdData_Valid     (RdData_Valid),
        .ALU_OUT          (ALU_OUT),
        .OUT_VALID        (OUT_VALID),
        .sys_ctrl_send_en (sys_ctrl_send_en),
        .Busy             (Busy),
        .TX_P_DATA        (TX_P_DATA),
        .TX_D_VLD         (TX_D_VLD),
        .alu_out_done     (alu_out_done),
        .ovf              (ovf)
    );

    typedef struct {
        logic        rd_v;
        logic [7:0]  rd;
        logic        alu_v;
        logic [15:0] alu;
        int          n;       // bytes expected
        logic [23:0] bytes;   // byte i at [8*i +: 8]
        int          done;
        int          ovfs;
    } vec_t;

    vec_t vecs [5];

    int errors = 0;
    int checks = 0;

    logic [7:0] sent [$];
    int done_cnt = 0;
    int ovf_cnt  = 0;
    logic vld_prev = 1'b0;
    int busy_cnt = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // UART TX model: Busy rises one cycle after a fresh TX_D_VLD, stays 10 cycles.
    initial begin
        Busy = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) Busy = 1'b0;
            end else if (TX_D_VLD && !Busy) begin
                Busy = 1'b1;
                busy_cnt = 10;
            end
        end
    end

    // Monitor: logs each byte at TX_D_VLD rise, counts pulses.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (TX_D_VLD && !vld_prev) sent.push_back(TX_P_DATA);
            vld_prev = TX_D_VLD;
            if (alu_out_done) done_cnt++;
            if (ovf) ovf_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sent_at(input int i);
        if (i < sent.size()) return {24'h0, sent[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clear_log();
        sent.delete();
        done_cnt = 0;
        ovf_cnt  = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        clear_log();
    endtask

    task automatic strobe(input logic rv, input logic [7:0] rd, input logic av, input logic [15:0] alu);
        @(negedge CLK);
        RdData       = rd;
        RdData_Valid = rv;
        ALU_OUT      = alu;
        OUT_VALID    = av;
        @(negedge CLK);
        RdData_Valid = 1'b0;
        OUT_VALID    = 1'b0;
    endtask

    task automatic wait_vld(input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge CLK);
            #2;
            if (TX_D_VLD) begin
                found = 1'b1;
                break;
            end
        end
        check(name, {31'h0, found}, 32'd1);
    endtask

    initial begin
        logic seen;
        logic prev_busy;
        logic fell;

        vecs[0] = '{rd_v:1'b1, rd:8'h5A, alu_v:1'b0, alu:16'h0000, n:1, bytes:24'h00005A, done:0, ovfs:0};
        vecs[1] = '{rd_v:1'b0, rd:8'h00, alu_v:1'b1, alu:16'h1234, n:2, bytes:24'h001234, done:1, ovfs:0};
        vecs[2] = '{rd_v:1'b1, rd:8'h77, alu_v:1'b1, alu:16'hABCD, n:3, bytes:24'hABCD77, done:1, ovfs:0};
        vecs[3] = '{rd_v:1'b1, rd:8'hFF, alu_v:1'b0, alu:16'h0000, n:1, bytes:24'h0000FF, done:0, ovfs:0};
        vecs[4] = '{rd_v:1'b0, rd:8'h00, alu_v:1'b1, alu:16'h00FF, n:2, bytes:24'h0000FF, done:1, ovfs:0};

        RST = 1'b1;
        RdData = 8'h00;
        RdData_Valid = 1'b0;
        ALU_OUT = 16'h0000;
        OUT_VALID = 1'b0;
        sys_ctrl_send_en = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        check("reset TX_P_DATA", {24'h0, TX_P_DATA}, 32'h0);
        check("reset TX_D_VLD", {31'h0, TX_D_VLD}, 32'h0);
        check("reset alu_out_done", {31'h0, alu_out_done}, 32'h0);
        check("reset ovf", {31'h0, ovf}, 32'h0);
        do_reset();

        // Table-driven transfers
        for (int v = 0; v < 5; v++) begin
            do_reset();
            strobe(vecs[v].rd_v, vecs[v].rd, vecs[v].alu_v, vecs[v].alu);
            repeat (60) @(posedge CLK);
            #2;
            check($sformatf("vec%0d byte count", v), sent.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n; i++)
                check($sformatf("vec%0d byte%0d", v, i), sent_at(i), {24'h0, vecs[v].bytes[8*i +: 8]});
            check($sformatf("vec%0d alu_out_done", v), done_cnt, vecs[v].done);
            check($sformatf("vec%0d ovf", v), ovf_cnt, vecs[v].ovfs);
            check($sformatf("vec%0d idle vld", v), {31'h0, TX_D_VLD}, 32'h0);
        end

        // Capture latency and data hold
        do_reset();
        @(negedge CLK);
        RdData = 8'h5A;
        RdData_Valid = 1'b1;
        @(posedge CLK);
        #1 RdData_Valid = 1'b0;
        #1 check("latency vld after capture edge", {31'h0, TX_D_VLD}, 32'h0);
        @(posedge CLK);
        #2;
        check("latency vld after launch edge", {31'h0, TX_D_VLD}, 32'h1);
        check("latency data", {24'h0, TX_P_DATA}, 32'h5A);
        repeat (30) @(posedge CLK);
        #2;
        check("hold vld low", {31'h0, TX_D_VLD}, 32'h0);
        check("hold data", {24'h0, TX_P_DATA}, 32'h5A);

        // Drop of a second ALU result while one is pending
        do_reset();
        strobe(1'b0, 8'h00, 1'b1, 16'h1234);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        ALU_OUT = 16'h9999;
        OUT_VALID = 1'b1;
        @(posedge CLK);
        #1 OUT_VALID = 1'b0;
        #1 check("ovf pulse", {31'h0, ovf}, 32'h1);
        @(posedge CLK);
        #2;
        check("ovf single cycle", {31'h0, ovf}, 32'h0);
        repeat (50) @(posedge CLK);
        #2;
        check("drop byte count", sent.size(), 2);
        check("drop byte0", sent_at(0), 32'h34);
        check("drop byte1", sent_at(1), 32'h12);
        check("drop ovf count", ovf_cnt, 1);
        check("drop done count", done_cnt, 1);

        // Enable gating
        do_reset();
        sys_ctrl_send_en = 1'b0;
        strobe(1'b1, 8'h11, 1'b0, 16'h0000);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK);
            #2;
            if (TX_D_VLD) seen = 1'b1;
        end
        check("en=0 blocks launch", {31'h0, seen}, 32'h0);
        sys_ctrl_send_en = 1'b1;
        repeat (30) @(posedge CLK);
        #2;
        check("en=1 byte count", sent.size(), 1);
        check("en=1 byte", sent_at(0), 32'h11);
        clear_log();
        strobe(1'b0, 8'h00, 1'b1, 16'h5566);
        wait_vld(10, "en low byte launch");
        @(negedge CLK);
        sys_ctrl_send_en = 1'b0;
        repeat (40) @(posedge CLK);
        #2;
        check("en drop byte count", sent.size(), 2);
        check("en drop byte0", sent_at(0), 32'h66);
        check("en drop byte1", sent_at(1), 32'h55);
        check("en drop done", done_cnt, 1);
        sys_ctrl_send_en = 1'b1;

        // Strobe on the clearing edge is accepted
        do_reset();
        strobe(1'b1, 8'h21, 1'b0, 16'h0000);
        prev_busy = 1'b0;
        fell = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #2;
            if (prev_busy && !Busy) begin
                fell = 1'b1;
                break;
            end
            prev_busy = Busy;
        end
        check("busy fall seen", {31'h0, fell}, 32'h1);
        RdData = 8'h22;
        RdData_Valid = 1'b1;
        @(posedge CLK);
        #1 RdData_Valid = 1'b0;
        repeat (30) @(posedge CLK);
        #2;
        check("clear-edge byte count", sent.size(), 2);
        check("clear-edge byte0", sent_at(0), 32'h21);
        check("clear-edge byte1", sent_at(1), 32'h22);
        check("clear-edge ovf", ovf_cnt, 0);

        // Reset during the ALU low byte
        do_reset();
        strobe(1'b0, 8'h00, 1'b1, 16'h4321);
        wait_vld(10, "abort low byte launch");
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        RdData = 8'hEE;
        RdData_Valid = 1'b1;
        @(posedge CLK);
        #2;
        check("abort TX_D_VLD", {31'h0, TX_D_VLD}, 32'h0);
        check("abort TX_P_DATA", {24'h0, TX_P_DATA}, 32'h0);
        check("abort alu_out_done", {31'h0, alu_out_done}, 32'h0);
        check("abort ovf", {31'h0, ovf}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        RdData_Valid = 1'b0;
        repeat (40) @(posedge CLK);
        #2;
        check("abort byte count", sent.size(), 1);
        check("abort byte0", sent_at(0), 32'h21);
        check("abort done count", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_send.md
SYS_CTRL_SEND -- requirements
Module: sys_ctrl_send

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of one UART byte and of register-file data.
REQ-002 Ports (name  direction  width  meaning):
 CLK  in  1  system clock; all logic on its rising edge.
 RST  in  1  reset; synchronous, active-high.
 RdData  in  DATA_WIDTH  register-file read data.
 RdData_Valid  in  1  one-cycle strobe qualifying RdData.
 ALU_OUT  in  2*DATA_WIDTH  ALU result.
 OUT_VALID  in  1  one-cycle strobe qualifying ALU_OUT.
 sys_ctrl_send_en  in  1  launch permission from the receive-side controller.
 Busy  in  1  UART TX busy, already synchronized to CLK.
 TX_P_DATA  out  DATA_WIDTH  byte to UART TX.
 TX_D_VLD  out  1  qualifies TX_P_DATA.
 alu_out_done  out  1  one-cycle pulse: both ALU bytes fully transmitted.
 ovf  out  1  one-cycle pulse: a result was dropped.

Function
REQ-003 Capture: RdData_Valid=1 loads rd_buf and sets rd_pend; OUT_VALID=1 loads alu_buf and sets alu_pend; capture happens in any state.
REQ-004 Drop: a strobe arriving while the same source's pend flag is set is discarded, buffer unchanged, ovf=1 next cycle.
REQ-005 States: IDLE, LOAD, WAIT_ACK, WAIT_DONE; encoding and byte-select bit local to the module.
REQ-006 IDLE -> LOAD when (rd_pend or alu_pend) and sys_ctrl_send_en=1 and Busy=0; rd_pend has priority over alu_pend.
REQ-007 Byte selection on IDLE->LOAD: rd_buf, or ALU low byte ALU_OUT[DATA_WIDTH-1:0] first, then high byte.
REQ-008 LOAD: TX_D_VLD=1 and TX_P_DATA=selected byte, both registered; held until Busy=1 is sampled, then -> WAIT_ACK with TX_D_VLD=0 the following cycle.
REQ-009 WAIT_ACK: -> WAIT_DONE once Busy=1 observed (immediate if already high); WAIT_DONE: wait for Busy=0.
REQ-010 On Busy falling in WAIT_DONE: register byte -> clear rd_pend, -> IDLE; ALU low byte -> LOAD with high byte (no re-arbitration, sys_ctrl_send_en ignored); ALU high byte -> clear alu_pend, alu_out_done=1 one cycle, -> IDLE.
REQ-011 Capture latency: strobe at edge N -> earliest TX_D_VLD=1 at edge N+2 (capture N, IDLE->LOAD N+1).
REQ-012 A strobe on the same cycle its pend flag clears is accepted, not dropped.
REQ-013 Simultaneous RdData_Valid and OUT_VALID: both captured; register byte sent first, ALU pair immediately after.
REQ-014 TX_P_DATA holds its last value when TX_D_VLD=0; it changes only on LOAD entry.
REQ-015 sys_ctrl_send_en=0 blocks only new transfers from IDLE; an in-flight ALU pair always completes.

Reset
REQ-016 RST=1 at a rising edge: state=IDLE, rd_pend=alu_pend=0, rd_buf=alu_buf=0, TX_P_DATA=0, TX_D_VLD=0, alu_out_done=0, ovf=0.
REQ-017 Reset mid-transfer aborts it without completing the byte; strobes coincident with RST are discarded.

Structure
REQ-018 Shared package: DATA_WIDTH default and frame command constants (0xAA, 0xBB, 0xCC, 0xDD) shared with the receive-side controller; state encoding stays local.
REQ-019 One natural sub-module: sys_ctrl_send_buf (single-entry buffer with pend flag and drop detect), instantiated once per source, widths DATA_WIDTH and 2*DATA_WIDTH.
REQ-020 All outputs registered; no combinational path from any input to any output.

Verification
REQ-021 RdData=0x5A strobe, Busy model 1 cycle after TX_D_VLD, 10 cycles busy -> TX_P_DATA=0x5A, TX_D_VLD at N+2, single byte, no alu_out_done.
REQ-022 ALU_OUT=0x1234 strobe -> bytes 0x34 then 0x12 in order, alu_out_done one pulse after second Busy fall.
REQ-023 RdData=0x77 and ALU_OUT=0xABCD on same cycle -> 0x77, 0xCD, 0xAB in order, no ovf.
REQ-024 Second OUT_VALID (0x9999) while 0x1234 pending -> ovf pulse, transmitted bytes still 0x34, 0x12.
REQ-025 sys_ctrl_send_en=0 with rd_pend set -> TX_D_VLD stays 0; drop en during ALU low byte -> high byte still sent.
REQ-026 RST=1 while in WAIT_DONE of ALU low byte -> all outputs 0 next cycle, no high byte, no alu_out_done.
